// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller:
// FSM states, power-on init bytes and the cmd_i field layout.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_EN_HIGH,
    ST_HOLD,
    ST_EXEC,
    ST_IDLE
  } lcd_state_e;

  localparam int ON_BIT   = 31;
  localparam int RS_BIT   = 8;
  localparam int DATA_MSB = 7;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  localparam int NUM_INIT   = 4;
  localparam int INIT_IDX_W = $clog2(NUM_INIT + 1);
  localparam int INIT_SEL_W = $clog2(NUM_INIT);
  localparam logic [7:0] INIT_SEQ [NUM_INIT] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execute wait.
  function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed FSM state; done is high at zero
// and the counter parks there until the next load.
module lcd_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up wait, fixed init sequence, then one
// user word per handshake, each framed as SETUP -> EN_HIGH -> HOLD -> EXEC.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP     = 20000,
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 80000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] cmd_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        busy_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_PWRUP, T_SETUP), max_int(T_EN, T_HOLD)),
                                 max_int(T_EXEC, T_EXEC_LONG));
  localparam int CNT_W = $clog2(T_MAX + 1);

  if (T_PWRUP < 1 || T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 ||
      T_EXEC < 1 || T_EXEC_LONG < 1) begin : g_param_check
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  // Handshake: a word transfers on a rising edge where cmd_valid_i and
  // cmd_ready_o are both 1; ready is high only in IDLE and valid is never queued.

  lcd_state_e            state_q, state_next;
  logic [CNT_W-1:0]      load_val;
  logic                  tmr_load, tmr_done;
  logic [7:0]            data_q;
  logic                  rs_q, on_q;
  logic [INIT_IDX_W-1:0] init_idx_q;
  logic                  init_pending, accept, init_load;
  logic                  unused_cmd;

  assign unused_cmd   = ^cmd_i[ON_BIT-1:RS_BIT+1];
  assign init_pending = (init_idx_q != INIT_IDX_W'(NUM_INIT));
  assign accept       = (state_q == ST_IDLE) && cmd_valid_i;
  assign init_load    = tmr_done && ((state_q == ST_PWRUP) ||
                                     ((state_q == ST_EXEC) && init_pending));

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_PWRUP;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_PWRUP:   if (tmr_done) state_next = ST_SETUP;
      ST_SETUP:   if (tmr_done) state_next = ST_EN_HIGH;
      ST_EN_HIGH: if (tmr_done) state_next = ST_HOLD;
      ST_HOLD:    if (tmr_done) state_next = ST_EXEC;
      ST_EXEC:    if (tmr_done) state_next = init_pending ? ST_SETUP : ST_IDLE;
      ST_IDLE:    if (cmd_valid_i) state_next = ST_SETUP;
      default:    state_next = ST_PWRUP;
    endcase
  end

  // Every transition reloads the timer with N-1 for the state being entered.
  always_comb begin
    load_val = '0;
    if (!rst_ni) begin
      load_val = CNT_W'(T_PWRUP - 1);
    end else begin
      case (state_next)
        ST_SETUP:   load_val = CNT_W'(T_SETUP - 1);
        ST_EN_HIGH: load_val = CNT_W'(T_EN - 1);
        ST_HOLD:    load_val = CNT_W'(T_HOLD - 1);
        ST_EXEC:    load_val = is_long_exec(rs_q, data_q) ? CNT_W'(T_EXEC_LONG - 1)
                                                          : CNT_W'(T_EXEC - 1);
        default:    load_val = '0;
      endcase
    end
  end

  assign tmr_load = !rst_ni || (state_next != state_q);

  lcd_timer #(.W(CNT_W)) u_timer (
    .clk      (clk_i),
    .load     (tmr_load),
    .load_val (load_val),
    .done     (tmr_done)
  );

  // Bus registers change only at accept or init-step load, both before SETUP.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q     <= '0;
      rs_q       <= 1'b0;
      on_q       <= 1'b1;
      init_idx_q <= '0;
    end else if (accept) begin
      data_q <= cmd_i[DATA_MSB:0];
      rs_q   <= cmd_i[RS_BIT];
      on_q   <= cmd_i[ON_BIT];
    end else if (init_load) begin
      data_q     <= INIT_SEQ[init_idx_q[INIT_SEL_W-1:0]];
      rs_q       <= 1'b0;
      init_idx_q <= init_idx_q + 1'b1;
    end
  end

  // Output logic.
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    busy_o      = (state_q != ST_IDLE);
    lcd_en_o    = (state_q == ST_EN_HIGH);
    lcd_rw_o    = 1'b0;
    lcd_data_o  = data_q;
    lcd_rs_o    = rs_q;
    lcd_on_o    = on_q;
  end

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter T_PWRUP, default 20000, cycles waited after reset before the init sequence starts.
REQ-002 Parameter T_SETUP, default 4, cycles RS/RW/DATA are stable before EN rises.
REQ-003 Parameter T_EN, default 12, cycles EN is held high.
REQ-004 Parameter T_HOLD, default 4, cycles RS/RW/DATA are held after EN falls.
REQ-005 Parameter T_EXEC, default 2000, execute-wait cycles for a normal command or data write.
REQ-006 Parameter T_EXEC_LONG, default 80000, execute-wait cycles for clear/home commands.
REQ-007 clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-008 rst_ni  input  1  reset, synchronous, active-low.
REQ-009 cmd_i  input  32  LCD register word: [31]=display power, [8]=RS, [7:0]=DATA; other bits ignored.
REQ-010 cmd_valid_i  input  1  cmd_i holds a new word.
REQ-011 cmd_ready_o  output  1  block can accept a word this cycle.
REQ-012 lcd_data_o  output  8  HD44780 data bus.
REQ-013 lcd_rs_o  output  1  register select.
REQ-014 lcd_rw_o  output  1  read/write; always 0 (write only).
REQ-015 lcd_en_o  output  1  enable strobe.
REQ-016 lcd_on_o  output  1  display power.
REQ-017 busy_o  output  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be PWRUP, SETUP, EN_HIGH, HOLD, EXEC, IDLE.
REQ-019 PWRUP SHALL last T_PWRUP cycles, then load init step 0 and enter SETUP.
REQ-020 Init sequence SHALL be RS=0 bytes 8'h38, 8'h0C, 8'h01, 8'h06, in that order, each through SETUP->EN_HIGH->HOLD->EXEC.
REQ-021 After EXEC of the last init step the FSM SHALL enter IDLE; after EXEC of a user word it SHALL enter IDLE.
REQ-022 cmd_ready_o SHALL be 1 only in IDLE; a word is accepted on a rising edge with cmd_valid_i=1 and cmd_ready_o=1.
REQ-023 On accept, cmd_i[8], cmd_i[7:0], cmd_i[31] SHALL be registered into lcd_rs_o, lcd_data_o, lcd_on_o and the FSM SHALL enter SETUP the next cycle.
REQ-024 SETUP lasts T_SETUP cycles with lcd_en_o=0; EN_HIGH lasts T_EN cycles with lcd_en_o=1; HOLD lasts T_HOLD cycles with lcd_en_o=0.
REQ-025 EXEC SHALL last T_EXEC_LONG cycles when RS=0 and DATA[7:2]=0 and DATA[1:0]!=0 (clear/home), else T_EXEC cycles.
REQ-026 lcd_data_o and lcd_rs_o SHALL NOT change from SETUP entry through HOLD exit.
REQ-027 Accept-to-ready latency SHALL be exactly 1+T_SETUP+T_EN+T_HOLD+T_EXEC(_LONG) cycles.
REQ-028 cmd_valid_i while not ready SHALL be ignored, not queued; the word is lost unless held by the producer.
REQ-029 Interval counter width SHALL be $clog2(max parameter + 1); counter loads N-1 on state entry and transitions at 0, no wrap.
REQ-030 lcd_on_o SHALL change only on accept; init steps leave it unchanged.

Reset
REQ-031 While rst_ni=0 at an edge: state=PWRUP, counter=T_PWRUP-1, init index=0, lcd_data_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_on_o=1, cmd_ready_o=0, busy_o=1.
REQ-032 Reset asserted mid-transfer SHALL drop lcd_en_o the following cycle and restart the full power-up/init sequence.

Structure
REQ-033 Package lcd_pkg SHALL hold the state enum, init byte table, and cmd_i field positions (ON_BIT=31, RS_BIT=8, DATA_MSB=7).
REQ-034 One sub-module lcd_timer (loadable down-counter, done flag) SHALL provide all interval timing.
REQ-035 All parameters SHALL be >=1; elaboration SHALL fail otherwise.

Verification (T_PWRUP=20, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=8, T_EXEC_LONG=30)
REQ-036 Reset release -> 20 cycles busy, then EN pulses carrying 38,0C,01,06; 01 followed by 30-cycle EXEC; cmd_ready_o rises after the 06 EXEC.
REQ-037 Accept cmd_i=32'h8000_0141 in IDLE -> lcd_rs_o=1, lcd_data_o=8'h41, lcd_on_o=1, EN high 4 cycles, ready again 17 cycles after accept.
REQ-038 Accept cmd_i=32'h0000_0001 -> lcd_on_o=0, rs=0, EXEC 30 cycles, ready 39 cycles after accept.
REQ-039 cmd_valid_i held high with changing cmd_i during a transfer -> lcd_data_o stable; only the word present when ready=1 is accepted.
REQ-040 rst_ni low during EN_HIGH -> lcd_en_o=0 next cycle; full init sequence repeats.
REQ-041 Back-to-back valid words 8'h48,8'h49 (RS=1) -> two transfers separated by exactly one IDLE cycle; lcd_rw_o=0 throughout.
